// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
//   SPI-slave register bank (mode 0, MSB first). A frame is a R/W bit
//   (1 = write), ADDR_W address bits and DATA_W data bits. Writes commit to a
//   NUM_REGS x DATA_W register file and pulse reg_wr_stb. Reads return a
//   register, the live state_indication value at STATUS_ADDR, or 0 for
//   unimplemented addresses. All SPI pins are synchronised into clk, which must
//   run at least 4x faster than spi_clk.
//
//   Optional build macro: SPI_BURST_EN
//     defined   : the data phase repeats for successive words at addr+1
//                 (wrapping NUM_REGS-1 -> 0) until chip select rises.
//     undefined : one word per frame; further clocks are ignored until cs rises.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   spi_clk/cs/mosi   SPI slave inputs (asynchronous to clk)
//   spi_miso          serial read data, 0 whenever spi_miso_oe is low
//   spi_miso_oe       high during the read data phase
//   state_indication  live status word returned for STATUS_ADDR
//   reg_wr_stb        one-clk pulse per committed write
//   reg_wr_addr/data  address/data of the committed write, valid with the strobe
// -----------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int                ADDR_W      = 7,
   parameter int                DATA_W      = 8,
   parameter int                NUM_REGS    = 128,
   parameter int                STATUS_ADDR = 127,
   parameter logic [DATA_W-1:0] RESET_VAL   = '0,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              spi_cs,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [DATA_W-1:0] state_indication,
   output logic              reg_wr_stb,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data
);

   localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_REGS);

   localparam logic [ADDR_W:0]   NUM_REGS_W = NUM_REGS[ADDR_W:0];
   localparam logic [ADDR_W-1:0] STATUS_A   = STATUS_ADDR[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(NUM_REGS - 1);
   localparam logic [CNT_W-1:0]  HDR_LAST   = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0]  DATA_LAST  = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

   // ---------------------------------------------------------------- state
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q,   cs_prev_d;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [ADDR_W-1:0]      hdr_sr_q, hdr_sr_d;
   logic [DATA_W-2:0]      data_sr_q, data_sr_d;
   logic [DATA_W-1:0]      rd_sr_q, rd_sr_d;
   logic                   rw_q, rw_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   miso_q, miso_d;
   logic                   oe_q, oe_d;
   logic                   wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]      wr_data_q, wr_data_d;
   logic                   wr_en_d;

   logic [DATA_W-1:0]      regs_q [NUM_REGS];

   // ------------------------------------------------------- edge detection
   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s &  sclk_prev_q;
   assign cs_rise   =  cs_s   & ~cs_prev_q;
   assign cs_fall   = ~cs_s   &  cs_prev_q;

   // Header/data words including the bit arriving on this rise.
   logic [ADDR_W:0]   hdr_full;
   logic [DATA_W-1:0] data_full;
   logic [ADDR_W-1:0] addr_nxt;

   assign hdr_full  = {hdr_sr_q, mosi_s};
   assign data_full = {data_sr_q, mosi_s};
   assign addr_nxt  = (addr_q == LAST_A) ? '0 : addr_q + ADDR_W'(1);

   // ----------------------------------------------------------- read mux
   // Word loaded into the read shifter: the header address at the end of the
   // header, the following address when a burst rolls over.
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_word;

   always_comb begin
      rd_addr = (state_q == DATA) ? addr_nxt : hdr_full[ADDR_W-1:0];
      if (rd_addr == STATUS_A)
         rd_word = state_indication;
      else if ({1'b0, rd_addr} >= NUM_REGS_W)
         rd_word = '0;
      else
         rd_word = regs_q[rd_addr[IDX_W-1:0]];
   end

   // ------------------------------------------------------ next-state logic
   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_d = sclk_s;
      cs_prev_d   = cs_s;

      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      hdr_sr_d  = hdr_sr_q;
      data_sr_d = data_sr_q;
      rd_sr_d   = rd_sr_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      miso_d    = miso_q;
      oe_d      = oe_q;
      wr_stb_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;

      if (cs_rise) begin
         // Deselect ends or aborts the frame from any state.
         state_d   = IDLE;
         bit_cnt_d = '0;
         hdr_sr_d  = '0;
         data_sr_d = '0;
         rd_sr_d   = '0;
         miso_d    = 1'b0;
         oe_d      = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = HDR;
                  bit_cnt_d = '0;
               end
            end
            HDR: begin
               if (sclk_rise) begin
                  hdr_sr_d  = hdr_full[ADDR_W-1:0];
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == HDR_LAST) begin
                     state_d   = DATA;
                     bit_cnt_d = '0;
                     rw_d      = hdr_full[ADDR_W];
                     addr_d    = hdr_full[ADDR_W-1:0];
                     rd_sr_d   = rd_word;
                  end
               end
            end
            DATA: begin
               if (sclk_fall && !rw_q) begin
                  // Read bits leave on falls so the master samples them on rises.
                  miso_d  = rd_sr_q[DATA_W-1];
                  rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
                  oe_d    = 1'b1;
               end else if (sclk_rise) begin
                  data_sr_d = data_full[DATA_W-2:0];
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == DATA_LAST) begin
                     bit_cnt_d = '0;
                     if (rw_q) begin
                        wr_stb_d  = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = data_full;
                        wr_en_d   = (addr_q != STATUS_A) &&
                                    ({1'b0, addr_q} < NUM_REGS_W);
                     end
`ifdef SPI_BURST_EN
                     addr_d = addr_nxt;
                     if (!rw_q)
                        rd_sr_d = rd_word;
`else
                     state_d = DONE;
                     miso_d  = 1'b0;
                     oe_d    = 1'b0;
`endif
                  end
               end
            end
            DONE: begin
               // Wait for chip select to rise; SPI clocks are ignored here.
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         hdr_sr_q    <= '0;
         data_sr_q   <= '0;
         rd_sr_q     <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         cs_sync_q   <= cs_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sclk_prev_q <= sclk_prev_d;
         cs_prev_q   <= cs_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         hdr_sr_q    <= hdr_sr_d;
         data_sr_q   <= data_sr_d;
         rd_sr_q     <= rd_sr_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
      end
   end

   // Register file updates in the same clk the strobe is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= RESET_VAL;
      end else if (wr_en_d) begin
         regs_q[addr_q[IDX_W-1:0]] <= wr_data_d;
      end
   end

   assign spi_miso    = miso_q & oe_q;
   assign spi_miso_oe = oe_q;
   assign reg_wr_stb  = wr_stb_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;

endmodule
